// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the cache/memory port arbiter.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cache_mem_arbiter_arb_grant2.sv
// Two-input picker: fixed data priority or round-robin against the last grant.
module arb_grant2
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   grant_i,
    output logic   grant_d
);

    // Resolve a conflict by priority or by alternating away from the last owner.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (req_i && req_d) begin
            if (DATA_FIRST || (last_grant == OWN_INST)) begin
                grant_d = 1'b1;
            end else begin
                grant_i = 1'b1;
            end
        end else begin
            grant_i = req_i;
            grant_d = req_d;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data cache
// miss paths. One transaction at a time; completion is a one-cycle dok pulse
// with the read data already registered on the owner's rdata output.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          DATA_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_cache_req,
    input  logic [ADDR_W-1:0] inst_cache_addr,
    output logic [DATA_W-1:0] inst_cache_rdata,
    output logic              inst_cache_dok,

    input  logic              data_cache_req,
    input  logic              data_cache_wr,
    input  logic [1:0]        data_cache_size,
    input  logic [ADDR_W-1:0] data_cache_addr,
    input  logic [DATA_W-1:0] data_cache_wdata,
    output logic [DATA_W-1:0] data_cache_rdata,
    output logic              data_cache_dok,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    owner_t     owner;
    owner_t     last_grant;
    logic       grant_i;
    logic       grant_d;
    logic       capture;

    arb_grant2 #(
        .DATA_FIRST (DATA_FIRST)
    ) u_grant (
        .req_i      (inst_cache_req),
        .req_d      (data_cache_req),
        .last_grant (last_grant),
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // Next-state logic; responses outside ADDR/DATA are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (grant_i || grant_d) begin
                    state_nxt = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (mem_addr_ok) begin
                    state_nxt = mem_data_ok ? ARB_DONE : ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (mem_data_ok) begin
                    state_nxt = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_nxt = ARB_IDLE;
            end
            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Read data is captured on data_ok, including the combined addr_ok+data_ok case.
    always_comb begin
        capture = 1'b0;
        if ((state == ARB_ADDR) && mem_addr_ok && mem_data_ok) begin
            capture = 1'b1;
        end else if ((state == ARB_DATA) && mem_data_ok) begin
            capture = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-side request registers: loaded at grant, request dropped on addr_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_INST;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_size  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_d) begin
                        owner     <= OWN_DATA;
                        mem_req   <= 1'b1;
                        mem_wr    <= data_cache_wr;
                        mem_size  <= data_cache_size;
                        mem_addr  <= data_cache_addr;
                        mem_wdata <= data_cache_wdata;
                    end else if (grant_i) begin
                        owner     <= OWN_INST;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_size  <= SZ_WORD;
                        mem_addr  <= inst_cache_addr;
                        mem_wdata <= '0;
                    end
                end
                ARB_ADDR: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completion: dok is high exactly in DONE, and only the owner's rdata is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_cache_dok   <= 1'b0;
            data_cache_dok   <= 1'b0;
            inst_cache_rdata <= '0;
            data_cache_rdata <= '0;
            last_grant       <= OWN_INST;
        end else begin
            inst_cache_dok <= 1'b0;
            data_cache_dok <= 1'b0;
            if (capture) begin
                if (owner == OWN_DATA) begin
                    data_cache_rdata <= mem_rdata;
                    data_cache_dok   <= 1'b1;
                end else begin
                    inst_cache_rdata <= mem_rdata;
                    inst_cache_dok   <= 1'b1;
                end
            end
            if (state == ARB_DONE) begin
                last_grant <= owner;
            end
        end
    end

endmodule
